// File: rtl/aircon_if.sv
// aircon_if: setting/sensor inputs and plant-driver outputs of the aircon controller
interface aircon_if;
  logic       power;
  logic       tick;
  logic [4:0] set_temp;
  logic [4:0] set_cap;
  logic [4:0] set_fan;
  logic [4:0] set_timer;
  logic [4:0] room_temp;
  logic       compressor;
  logic [1:0] comp_level;
  logic [2:0] fan_level;
  logic [2:0] timer_rem;
  logic [2:0] state;
  logic       timer_done;
  modport master(output power, tick, set_temp, set_cap, set_fan, set_timer, room_temp,
                 input compressor, comp_level, fan_level, timer_rem, state, timer_done);
  modport slave(input power, tick, set_temp, set_cap, set_fan, set_timer, room_temp,
                output compressor, comp_level, fan_level, timer_rem, state, timer_done);
endinterface

// File: rtl/aircon_controller.sv
// aircon_controller: five-state sequencer with compressor short-cycle lockout and auto-off timer
// Define AIRCON_HYSTERESIS_EN for a two-threshold demand band around set_temp.
module aircon_controller #(
  parameter int MIN_OFF_TICKS = 3
) (
  input logic     clk,
  input logic     rst,
  aircon_if.slave bus
);
  typedef enum logic [2:0] {OFF, IDLE, LOCKOUT, COOL, HALT} state_t;
  state_t st;
  logic [2:0] lk, tmr, fan_sel;
  logic done, demand, running, expire, reload, unused_bits;
  always_comb begin
`ifdef AIRCON_HYSTERESIS_EN
    demand = (st == COOL) ? !({1'b0, bus.room_temp} < {1'b0, bus.set_temp})
                          : ({1'b0, bus.room_temp} > {1'b0, bus.set_temp} + 6'd1);
`else
    demand = bus.room_temp > bus.set_temp;
`endif
    running = st inside {IDLE, LOCKOUT, COOL};
    expire  = bus.power && running && bus.tick && tmr == 3'd1;
    reload  = bus.power && st == COOL && (expire || !demand);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= OFF;
      lk   <= '0;
      tmr  <= '0;
      done <= 1'b0;
    end else begin
      done <= expire;
      lk   <= reload ? 3'(MIN_OFF_TICKS) : (bus.tick && lk != 0) ? lk - 3'd1 : lk;
      if (!bus.power) begin
        st  <= OFF;
        tmr <= '0;
      end else if (st == OFF) begin
        st  <= IDLE;
        tmr <= bus.set_timer[2:0];
      end else if (expire) begin
        st  <= HALT;
        tmr <= '0;
      end else if (running) begin
        if (bus.tick && tmr != 0) tmr <= tmr - 3'd1;
        st <= !demand ? IDLE : (lk == 0 || st == COOL) ? COOL : LOCKOUT;
      end
    end
  end
  assign fan_sel        = bus.set_fan[2:0];
  assign bus.compressor = st == COOL;
  assign bus.comp_level = st == COOL ? bus.set_cap[1:0] : 2'd0;
  assign bus.fan_level  = (st == OFF || st == HALT) ? 3'd0 : fan_sel != 0 ? fan_sel :
                          st == COOL ? {1'b0, bus.set_cap[1:0]} + 3'd1 : 3'd1;
  assign bus.timer_rem  = tmr;
  assign bus.state      = st;
  assign bus.timer_done = done;
  assign unused_bits    = ^{bus.set_cap[4:2], bus.set_fan[4:3], bus.set_timer[4:3]};
endmodule

// File: tb/tb_aircon_controller.sv
// tb_aircon_controller: directed test-plan scenarios plus randomized run against a behavioural model
module tb_aircon_controller;
  localparam int MIN_OFF = 3;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int ms, ml, mt, md;
  aircon_if bus();
  aircon_controller #(.MIN_OFF_TICKS(MIN_OFF)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit want_cool();
    int r = int'(bus.room_temp);
    int s = int'(bus.set_temp);
`ifdef AIRCON_HYSTERESIS_EN
    return (ms == 3) ? !(r < s) : (r > s + 1);
`else
    return r > s;
`endif
  endfunction
  task automatic model_reset();
    ms = 0; ml = 0; mt = 0; md = 0;
  endtask
  task automatic model_step();
    bit d = want_cool();
    bit active = ms >= 1 && ms <= 3;
    bit exp = bus.power && active && bus.tick && mt == 1;
    int old_lock = ml;
    md = exp;
    if (bus.power && ms == 3 && (exp || !d)) ml = MIN_OFF;
    else if (bus.tick && ml > 0) ml = ml - 1;
    if (!bus.power) begin ms = 0; mt = 0; end
    else if (ms == 0) begin ms = 1; mt = bus.set_timer % 8; end
    else if (exp) begin ms = 4; mt = 0; end
    else if (active) begin
      if (bus.tick && mt > 0) mt = mt - 1;
      if (!d) ms = 1;
      else if (ms == 3 || old_lock == 0) ms = 3;
      else ms = 2;
    end
  endtask
  task automatic compare_all();
    int f = bus.set_fan % 8;
    int efan = (ms == 0 || ms == 4) ? 0 : (f != 0) ? f : (ms == 3) ? bus.set_cap % 4 + 1 : 1;
    chk("state", bus.state, ms);
    chk("compressor", bus.compressor, ms == 3);
    chk("comp_level", bus.comp_level, ms == 3 ? bus.set_cap % 4 : 0);
    chk("fan_level", bus.fan_level, efan);
    chk("timer_rem", bus.timer_rem, mt);
    chk("timer_done", bus.timer_done, md);
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask
  initial begin
    rst = 1'b1;
    bus.power = 0; bus.tick = 0; bus.set_temp = 20; bus.set_cap = 2;
    bus.set_fan = 0; bus.set_timer = 0; bus.room_temp = 24;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_all();
    // power-up into cooling
    bus.power = 1;
    cycle(); chk("tp1_idle", bus.state, 1);
    cycle(); chk("tp1_cool", bus.state, 3);
    chk("tp1_comp", bus.compressor, 1); chk("tp1_lvl", bus.comp_level, 2); chk("tp1_fan", bus.fan_level, 3);
    // release then immediate re-demand waits out the lockout
    bus.room_temp = 18; cycle(); chk("tp2_idle", bus.state, 1);
    bus.room_temp = 25; cycle(); chk("tp2_lockout", bus.state, 2);
    bus.tick = 1;
    repeat (3) begin cycle(); chk("tp2_hold", bus.state, 2); end
    bus.tick = 0; cycle(); chk("tp2_cool", bus.state, 3);
    // auto-off timer
    bus.power = 0; bus.room_temp = 18; cycle(); chk("tp3_off", bus.state, 0);
    bus.set_timer = 2; bus.power = 1; cycle(); chk("tp3_rem2", bus.timer_rem, 2);
    bus.tick = 1; cycle(); chk("tp3_rem1", bus.timer_rem, 1);
    cycle(); chk("tp3_halt", bus.state, 4); chk("tp3_done", bus.timer_done, 1); chk("tp3_rem0", bus.timer_rem, 0);
    bus.tick = 0; cycle(); chk("tp3_done_low", bus.timer_done, 0); chk("tp3_held", bus.state, 4);
    bus.power = 0; cycle(); chk("tp3_off2", bus.state, 0);
    // power loss coincident with expiry
    bus.set_timer = 1; bus.room_temp = 25; bus.power = 1; cycle(); chk("tp4_idle", bus.state, 1);
    cycle(); chk("tp4_cool", bus.state, 3);
    bus.power = 0; bus.tick = 1; cycle();
    chk("tp4_off", bus.state, 0); chk("tp4_nodone", bus.timer_done, 0); chk("tp4_fan", bus.fan_level, 0);
    bus.tick = 0; bus.power = 1; bus.set_timer = 0;
    cycle(); cycle(); chk("rst_pre_cool", bus.state, 3);
    // asynchronous reset mid-cooling
    #2 rst = 1'b1;
    #1 chk("rst_comp", bus.compressor, 0); chk("rst_state", bus.state, 0); chk("rst_rem", bus.timer_rem, 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    bus.room_temp = 18; cycle(); chk("post_rst_idle", bus.state, 1);
`ifdef AIRCON_HYSTERESIS_EN
    bus.room_temp = 21; cycle(); chk("hy_band_idle", bus.state, 1);
    bus.room_temp = 22; cycle(); chk("hy_cool", bus.state, 3);
    bus.room_temp = 20; cycle(); chk("hy_band_cool", bus.state, 3);
    bus.room_temp = 19; cycle(); chk("hy_idle", bus.state, 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      bus.power = ($urandom % 40) != 0;
      bus.tick = ($urandom % 3) == 0;
      if ($urandom % 200 == 0) bus.set_temp = 5'($urandom % 32);
      bus.room_temp = 5'(int'(bus.set_temp) + int'($urandom % 7) - 3);
      bus.set_cap = 5'($urandom);
      bus.set_fan = 5'($urandom);
      bus.set_timer = 5'($urandom);
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aircon_controller.md
# aircon_controller

Sequencing controller for the air-conditioner datapath. It takes the stored setting registers (setpoint temperature, capacity, fan speed, timer) plus a room-temperature sensor and a slow time-base tick, and produces these outputs:
- compressor enable and compressor level
- effective fan level
- remaining-timer count
- a one-cycle timer-expiry pulse

It runs a five-state machine with compressor short-cycle lockout and auto-off timer. It sits between the setting memories and the plant drivers.

## Interface
Parameters:
- MIN_OFF_TICKS, 3: ticks the compressor must stay off after any stop (1..7).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- power  input  1  unit power switch
- tick  input  1  one-cycle time-base strobe (one timer unit)
- set_temp  input  5  setpoint, unsigned
- set_cap  input  5  capacity; bits [1:0] used, [4:2] ignored
- set_fan  input  5  fan speed; bits [2:0] used, 0 = auto
- set_timer  input  5  auto-off timer; bits [2:0] used, 0 = disabled
- room_temp  input  5  measured room temperature, unsigned
- compressor  output  1  compressor enable
- comp_level  output  2  compressor capacity level
- fan_level  output  3  effective fan speed
- timer_rem  output  3  remaining timer units
- state  output  3  OFF=0, IDLE=1, LOCKOUT=2, COOL=3, HALT=4
- timer_done  output  1  one-cycle pulse on timer expiry

## Operation
- demand:
  - Assert condition: room_temp > set_temp.
  - Release condition: room_temp <= set_temp.
  - Both are 5-bit unsigned compares.
- Transition priority, highest first: power low, then timer expiry, then demand.
- Any state with power=0 goes to OFF.
- OFF, power=1 goes to IDLE and loads timer_rem = set_timer[2:0].
- IDLE:
  - demand with lockout_cnt=0 goes to COOL.
  - demand with lockout_cnt≠0 goes to LOCKOUT.
- LOCKOUT:
  - no demand goes to IDLE.
  - demand with lockout_cnt=0 goes to COOL.
- COOL, demand released: goes to IDLE and loads lockout_cnt = MIN_OFF_TICKS.
- Timer expiry goes to HALT and pulses timer_done. Expiry applies in IDLE, LOCKOUT and COOL, and is defined as tick while timer_rem=1 and timer armed.
  - Leaving COOL this way also loads lockout_cnt.
- HALT holds until power=0 (re-power required).
- Timer:
  - Armed when the loaded value is nonzero.
  - Decrements on tick only in IDLE, LOCKOUT and COOL.
  - Frozen in HALT; holds 0 after expiry.
  - set_timer changes after power-on are ignored until the next OFF→IDLE.
- lockout_cnt:
  - 3-bit, reset 0.
  - Decrements on tick whenever nonzero, in every state including OFF and HALT.
  - A reload in the same cycle as a tick wins; no decrement that cycle.
- Outputs are decoded from registered state and counters:
  - compressor = (state==COOL).
  - comp_level = set_cap[1:0] in COOL, else 0.
  - fan_level in OFF and HALT: 0.
  - fan_level in IDLE and LOCKOUT: set_fan[2:0] if nonzero, else 1.
  - fan_level in COOL: set_fan[2:0] if nonzero, else set_cap[1:0]+1 (range 1..4).
  - timer_rem = counter value; reads 0 in OFF.
- Inputs other than power and tick may change at any cycle; they are sampled each clock.

## Timing
- Reset (async):
  - state=OFF, lockout_cnt=0, timer counter=0.
  - Outputs: compressor=0, comp_level=0, fan_level=0, timer_rem=0, timer_done=0.
- Latency: input condition at edge N produces the new state/outputs valid after edge N (one clock).
- timer_done is registered: high for exactly the one cycle after the expiry edge.
- Simultaneous power=0 and expiry: go to OFF, no timer_done.
- Simultaneous demand release and expiry in COOL: go to HALT, lockout loaded once, timer_done pulses.
- tick asserted for several consecutive cycles counts once per cycle.
- Reset mid-COOL: compressor drops asynchronously, and lockout_cnt clears to 0 (no lockout enforced after reset).
- No wrap-around: counters never decrement below 0.

## Configuration
- AIRCON_HYSTERESIS_EN defined:
  - demand asserts when room_temp > set_temp+1.
  - demand releases when room_temp < set_temp.
  - Compares are 6-bit, so there is no wrap at set_temp=31.
  - Room temperatures inside the band keep the current COOL/non-COOL decision.
- Undefined: single-threshold compare as in Operation.

## Test plan
- Reset, power=1, set_temp=20, room_temp=24, set_cap=2, set_fan=0 -> IDLE after one edge, COOL after the next; compressor=1, comp_level=2, fan_level=3.
- From COOL, room_temp=20 -> IDLE, lockout_cnt=3; set room_temp=25 immediately -> LOCKOUT, then COOL one edge after the third tick.
- set_timer=2, power on in IDLE, two ticks -> timer_rem 2→1→0, HALT, timer_done high for one cycle; power stays high -> HALT held; power=0 -> OFF.
- In COOL, assert power=0 and a tick expiring the timer in the same cycle -> OFF, timer_done stays 0, all outputs 0.
- With AIRCON_HYSTERESIS_EN, set_temp=20:
  - room_temp=21 from IDLE -> stays IDLE.
  - room_temp=22 -> COOL.
  - room_temp=20 -> stays COOL.
  - room_temp=19 -> IDLE.
- Assert rst mid-COOL -> compressor low without a clock edge, state=0, timer_rem=0.
